// File: rtl/button_event_classifier.sv
// button_event_classifier
// Classifies debounced button presses as short, double or long and emits a
// one-cycle registered pulse per classified press. Optional build macro
// HOLD_REPEAT_EN adds periodic hold_repeat pulses while a long press is held;
// without it hold_repeat is tied low and no repeat counter exists.
module button_event_classifier #(
    parameter int unsigned LONG_CYCLES       = 25000000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 12500000,
    parameter int unsigned REPEAT_CYCLES     = 5000000,
    parameter int unsigned CNT_W             = 25
) (
    input  logic       src_clk,
    input  logic       rst,
    input  logic       pb_in,
    input  logic       en,
    output logic       short_press,
    output logic       double_press,
    output logic       long_press,
    output logic       hold_repeat,
    output logic       pressed,
    output logic [7:0] event_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HELD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(DOUBLE_GAP_CYCLES);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pb_q;
    logic             pb_prev_q;
    logic             rise;
    logic             fall;
    logic             short_q;
    logic             double_q;
    logic             long_q;
    logic [7:0]       event_cnt_q;

    // Edge detection on the registered level and saturating duration increment
    always_comb begin
        rise  = pb_q & ~pb_prev_q;
        fall  = ~pb_q & pb_prev_q;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Input stage, classification FSM, event pulses and event counter
    always_ff @(posedge src_clk) begin
        if (rst) begin
            pb_q        <= pb_in;
            pb_prev_q   <= pb_in;
            state_q     <= IDLE;
            cnt_q       <= '0;
            short_q     <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
            event_cnt_q <= '0;
        end else begin
            pb_q      <= pb_in;
            pb_prev_q <= pb_q;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= PRESS1;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    PRESS1: begin
                        if (cnt_q == LONG_C) begin
                            long_q      <= 1'b1;
                            event_cnt_q <= event_cnt_q + 8'd1;
                            state_q     <= LONG_HELD;
                        end else if (fall) begin
                            state_q <= WAIT2;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    WAIT2: begin
                        // A rise on the timeout cycle still takes the double path
                        if (rise) begin
                            state_q <= PRESS2;
                            cnt_q   <= CNT_W'(1);
                        end else if (cnt_q == GAP_C) begin
                            short_q     <= 1'b1;
                            event_cnt_q <= event_cnt_q + 8'd1;
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    PRESS2: begin
                        if (cnt_q == LONG_C) begin
                            long_q      <= 1'b1;
                            event_cnt_q <= event_cnt_q + 8'd1;
                            state_q     <= LONG_HELD;
                        end else if (fall) begin
                            double_q    <= 1'b1;
                            event_cnt_q <= event_cnt_q + 8'd1;
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                    LONG_HELD: begin
                        if (fall) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] rep_q;
    logic             hold_repeat_q;

    // Repeat timer while long-held; rep_q+1 is the cycle count since long_press,
    // so the first pulse lands REPEAT_CYCLES cycles after the long_press pulse
    always_ff @(posedge src_clk) begin
        if (rst || !en) begin
            rep_q         <= '0;
            hold_repeat_q <= 1'b0;
        end else begin
            hold_repeat_q <= 1'b0;
            if (state_q == LONG_HELD && !fall) begin
                if (rep_q == REP_LAST) begin
                    hold_repeat_q <= 1'b1;
                    rep_q         <= '0;
                end else begin
                    rep_q <= rep_q + CNT_W'(1);
                end
            end else begin
                rep_q <= '0;
            end
        end
    end

    assign hold_repeat = hold_repeat_q;
`else
    assign hold_repeat = 1'b0;
`endif

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign pressed      = pb_q;
    assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Testbench for button_event_classifier: directed press sequences with a
// scoreboard of expected pulse kinds and cycle numbers.
module tb_button_event_classifier;

    localparam int unsigned LC = 20;
    localparam int unsigned DG = 10;
    localparam int unsigned RC = 5;
    localparam int unsigned CW = 8;

    localparam logic [3:0] K_SHORT  = 4'b0001;
    localparam logic [3:0] K_DOUBLE = 4'b0010;
    localparam logic [3:0] K_LONG   = 4'b0100;
    localparam logic [3:0] K_HOLD   = 4'b1000;

    typedef struct {
        logic [3:0]  kinds;
        int unsigned cyc;
    } exp_t;

    logic       src_clk = 1'b0;
    logic       rst;
    logic       pb_in;
    logic       en;
    logic       short_press;
    logic       double_press;
    logic       long_press;
    logic       hold_repeat;
    logic       pressed;
    logic [7:0] event_cnt;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  ev_exp = 8'd0;
    exp_t        sb[$];

    button_event_classifier #(
        .LONG_CYCLES      (LC),
        .DOUBLE_GAP_CYCLES(DG),
        .REPEAT_CYCLES    (RC),
        .CNT_W            (CW)
    ) dut (
        .src_clk     (src_clk),
        .rst         (rst),
        .pb_in       (pb_in),
        .en          (en),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .hold_repeat (hold_repeat),
        .pressed     (pressed),
        .event_cnt   (event_cnt)
    );

    always #5 src_clk = ~src_clk;

    always @(posedge src_clk) cyc++;

    // Pulse monitor: every pulse cycle must match the head of the scoreboard
    always @(posedge src_clk) begin
        logic [3:0] obs;
        exp_t       e;
        #1;
        obs = {hold_repeat, long_press, double_press, short_press};
        if (obs != 4'b0000) begin
            n_cmp++;
            if (sb.size() == 0) begin
                assert (obs === 4'b0000) else begin
                    n_err++;
                    $error("FAIL unexpected_pulse cyc=%0d obs=%b exp=%b", cyc, obs, 4'b0000);
                end
            end else begin
                e = sb.pop_front();
                assert (obs === e.kinds && cyc === e.cyc) else begin
                    n_err++;
                    $error("FAIL pulse obs=%b@%0d exp=%b@%0d", obs, cyc, e.kinds, e.cyc);
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge src_clk);
    endtask

    task automatic push(input logic [3:0] k, input int unsigned c);
        sb.push_back('{kinds: k, cyc: c});
        if (k != K_HOLD) ev_exp = ev_exp + 8'd1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_drained(input string tag);
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL %s missing_pulses obs=%0d exp=0", tag, sb.size());
        end
    endtask

    initial begin
        int unsigned r;
        int unsigned f;

        // Reset values
        rst   = 1'b1;
        pb_in = 1'b0;
        en    = 1'b1;
        step(3);
        check("rst_pulses", {4'b0000, hold_repeat, long_press, double_press, short_press}, 8'd0);
        check("rst_event_cnt", event_cnt, 8'd0);
        check("rst_pressed", {7'd0, pressed}, 8'd0);
        rst = 1'b0;
        step(3);

        // 1: single short press
        pb_in = 1'b1;
        step(5);
        pb_in = 1'b0;
        f = cyc + 1;
        push(K_SHORT, f + DG + 1);
        step(20);
        check_drained("t1_short");
        check("t1_event_cnt", event_cnt, ev_exp);

        // 2: double press
        pb_in = 1'b1;
        step(5);
        pb_in = 1'b0;
        step(4);
        pb_in = 1'b1;
        step(5);
        pb_in = 1'b0;
        f = cyc + 1;
        push(K_DOUBLE, f + 1);
        step(20);
        check_drained("t2_double");
        check("t2_event_cnt", event_cnt, ev_exp);

        // 3: long press held 35 cycles
        pb_in = 1'b1;
        r = cyc + 1;
        push(K_LONG, r + LC + 1);
`ifdef HOLD_REPEAT_EN
        for (int unsigned k = r + LC + 1 + RC; k <= r + 35; k += RC) push(K_HOLD, k);
`endif
        step(35);
        check("t3_pressed", {7'd0, pressed}, 8'd1);
        pb_in = 1'b0;
        step(20);
        check_drained("t3_long");
        check("t3_event_cnt", event_cnt, ev_exp);

        // 4: reset mid-press while held; no rise after reset
        pb_in = 1'b1;
        step(8);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ev_exp = 8'd0;
        step(40);
        check_drained("t4_held");
        check("t4_pressed_held", {7'd0, pressed}, 8'd1);
        check("t4_event_cnt_rst", event_cnt, ev_exp);
        pb_in = 1'b0;
        step(5);
        pb_in = 1'b1;
        step(5);
        pb_in = 1'b0;
        f = cyc + 1;
        push(K_SHORT, f + DG + 1);
        step(20);
        check_drained("t4_short");
        check("t4_event_cnt", event_cnt, ev_exp);

        // 5: disable inside WAIT2 drops the pending short
        pb_in = 1'b1;
        step(5);
        pb_in = 1'b0;
        step(4);
        en = 1'b0;
        step(3);
        en = 1'b1;
        step(20);
        check_drained("t5_en");
        check("t5_event_cnt", event_cnt, ev_exp);

        // 6: 256 short presses wrap event_cnt
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        ev_exp = 8'd0;
        step(2);
        for (int unsigned i = 0; i < 256; i++) begin
            pb_in = 1'b1;
            step(3);
            pb_in = 1'b0;
            f = cyc + 1;
            push(K_SHORT, f + DG + 1);
            step(14);
            check("t6_event_cnt", event_cnt, 8'(i + 1));
        end
        check_drained("t6_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
